// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking slot ledger.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        CALC,
        DONE
    } state_t;

    localparam int DEFAULT_N_SLOTS = 6;
    localparam int DEFAULT_SLOT_W  = 4;
    localparam int DEFAULT_TIME_W  = 11;
    localparam int DEFAULT_FEE_W   = 16;
    localparam int DEFAULT_RATE    = 1;
    localparam int DEFAULT_GRACE   = 0;

    // Slot IDs are 1-based; 0 is reserved as "no slot".
    function automatic logic slot_valid(input logic [31:0] slot, input int n_slots);
        return (slot != 32'd0) && (slot <= 32'(n_slots));
    endfunction

    function automatic logic fee_overflow(input logic [63:0] product, input int fee_w);
        return (fee_w < 64) && ((product >> fee_w) != 64'd0);
    endfunction

endpackage

// File: rtl/parking_fee_calc.sv
// Combinational fee: grace subtract, per-unit multiply and clamp to the fee width.
module parking_fee_calc
    import parking_pkg::*;
#(
    parameter int TIME_W = DEFAULT_TIME_W,
    parameter int FEE_W  = DEFAULT_FEE_W,
    parameter int RATE   = DEFAULT_RATE,
    parameter int GRACE  = DEFAULT_GRACE
) (
    input  logic [TIME_W-1:0] elapsed,
    output logic [FEE_W-1:0]  fee,
    output logic              sat
);

    // Wide enough that billable * RATE can never wrap.
    localparam int PROD_W = TIME_W + $clog2(RATE + 1);

    logic [PROD_W-1:0] billable;
    logic [PROD_W-1:0] product;

    // NOTE: every output is assigned a default first so no latch is inferred.
    always_comb begin
        billable = '0;
        if (32'(elapsed) > 32'(GRACE))
            billable = PROD_W'(32'(elapsed) - 32'(GRACE));
        product = billable * PROD_W'(RATE);
        sat     = fee_overflow(64'(product), FEE_W);
        fee     = sat ? '1 : FEE_W'(product);
    end

endmodule

// File: rtl/parking_ledger.sv
// N-slot parking ledger: check-in timestamps, wrap-safe elapsed time and billed fee.
module parking_ledger
    import parking_pkg::*;
#(
    parameter int N_SLOTS = DEFAULT_N_SLOTS,
    parameter int SLOT_W  = DEFAULT_SLOT_W,
    parameter int TIME_W  = DEFAULT_TIME_W,
    parameter int FEE_W   = DEFAULT_FEE_W,
    parameter int RATE    = DEFAULT_RATE,
    parameter int GRACE   = DEFAULT_GRACE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TIME_W-1:0]  timer,
    input  logic               req_valid,
    input  logic [SLOT_W-1:0]  req_slot,
    output logic               req_ready,
    output logic               done,
    output logic               evt_in,
    output logic               evt_out,
    output logic               err,
    output logic [FEE_W-1:0]   fee,
    output logic               fee_sat,
    output logic [TIME_W-1:0]  elapsed,
    output logic [N_SLOTS-1:0] occupied,
    output logic [SLOT_W-1:0]  free_count
);

    state_t state, state_next;

    logic [SLOT_W-1:0]  slot_q;
    logic [TIME_W-1:0]  t_req;
    logic [TIME_W-1:0]  stamp [N_SLOTS];
    logic [TIME_W-1:0]  stay;
    logic               in_q, out_q, err_q, sat_q;

    logic [N_SLOTS-1:0] slot_sel;
    logic [TIME_W-1:0]  slot_stamp;
    logic               slot_ok, slot_busy;
    logic [FEE_W-1:0]   calc_fee;
    logic               calc_sat;

    // One-hot decode of the latched slot; an invalid ID decodes to all zeros.
    always_comb begin
        slot_sel   = '0;
        slot_stamp = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_sel[i] = (slot_q == SLOT_W'(i + 1));
            if (slot_q == SLOT_W'(i + 1))
                slot_stamp = stamp[i];
        end
        slot_ok   = slot_valid(32'(slot_q), N_SLOTS);
        slot_busy = |(occupied & slot_sel);
    end

    parking_fee_calc #(
        .TIME_W (TIME_W),
        .FEE_W  (FEE_W),
        .RATE   (RATE),
        .GRACE  (GRACE)
    ) u_fee_calc (
        .elapsed (stay),
        .fee     (calc_fee),
        .sat     (calc_sat)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = LOOKUP;
            LOOKUP:  state_next = (slot_ok && slot_busy) ? CALC : DONE;
            CALC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        done      = (state == DONE);
        evt_in    = (state == DONE) && in_q;
        evt_out   = (state == DONE) && out_q;
        err       = (state == DONE) && err_q;
        fee_sat   = (state == DONE) && sat_q;
    end

    // NOTE: the stamp array is plain flops, so it takes the asynchronous reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            t_req      <= '0;
            stay       <= '0;
            elapsed    <= '0;
            fee        <= '0;
            occupied   <= '0;
            in_q       <= 1'b0;
            out_q      <= 1'b0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
            free_count <= SLOT_W'(N_SLOTS);
            for (int i = 0; i < N_SLOTS; i++)
                stamp[i] <= '0;
        end else begin
            free_count <= SLOT_W'(N_SLOTS - $countones(occupied));
            case (state)
                IDLE: begin
                    in_q  <= 1'b0;
                    out_q <= 1'b0;
                    err_q <= 1'b0;
                    sat_q <= 1'b0;
                    if (req_valid) begin
                        slot_q <= req_slot;
                        t_req  <= timer;
                    end
                end
                LOOKUP: begin
                    if (!slot_ok) begin
                        err_q <= 1'b1;
                    end else if (!slot_busy) begin
                        for (int i = 0; i < N_SLOTS; i++)
                            if (slot_sel[i]) stamp[i] <= t_req;
                        occupied <= occupied | slot_sel;
                        in_q     <= 1'b1;
                        fee      <= '0;
                        sat_q    <= 1'b0;
                    end else begin
                        // Modular subtraction keeps timer wrap-around transparent.
                        stay <= t_req - slot_stamp;
                    end
                end
                CALC: begin
                    for (int i = 0; i < N_SLOTS; i++)
                        if (slot_sel[i]) stamp[i] <= '0;
                    occupied <= occupied & ~slot_sel;
                    fee      <= calc_fee;
                    sat_q    <= calc_sat;
                    elapsed  <= stay;
                    out_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/parking_ledger.md
# parking_ledger

Parametrised slot ledger for the parking controller: records a check-in timestamp per slot and, on check-out, computes the elapsed time (wrap-safe) and a billed fee with grace period, per-unit rate and saturation. It sits between the slot-select/button front end and the fee display, replacing the single-edge, fixed-six-slot check-in/out logic with a clocked, handshaked, N-slot engine.

## Interface
- N_SLOTS, 6: number of parking slots; slot IDs are 1..N_SLOTS.
- SLOT_W, 4: width of slot ID; requires 2^SLOT_W > N_SLOTS.
- TIME_W, 11: width of free-running timer and stored timestamps.
- FEE_W, 16: width of fee output.
- RATE, 1: fee units per elapsed time unit; constant ≥ 1.
- GRACE, 0: elapsed time units not billed.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- timer  in  TIME_W  current time; free-running, wraps modulo 2^TIME_W.
- req_valid  in  1  request strobe.
- req_slot  in  SLOT_W  slot ID for the request.
- req_ready  out  1  high only in IDLE.
- done  out  1  one-cycle result pulse.
- evt_in  out  1  with done: the request was a check-in.
- evt_out  out  1  with done: the request was a check-out.
- err  out  1  with done: invalid slot ID; no state change.
- fee  out  FEE_W  fee of the last completed request; held between requests.
- fee_sat  out  1  with done: fee was clamped.
- elapsed  out  TIME_W  elapsed time of the last check-out.
- occupied  out  N_SLOTS  bit i-1 set when slot i is occupied.
- free_count  out  SLOT_W  number of free slots.

## Operation
- FSM states: IDLE, LOOKUP, CALC, DONE.
- IDLE: req_ready=1. If req_valid, latch req_slot and timer as t_req, then go to LOOKUP.
- LOOKUP, invalid slot (0 or > N_SLOTS): set err, go to DONE.
- LOOKUP, slot free: stamp[slot] ← t_req, set occupied bit, set evt_in, fee ← 0, fee_sat ← 0, go to DONE (CALC skipped).
- LOOKUP, slot occupied: elapsed ← (t_req − stamp[slot]) mod 2^TIME_W, go to CALC.
- CALC: billable = elapsed > GRACE ? elapsed − GRACE : 0. Product = billable × RATE, computed at full width TIME_W + clog2(RATE+1).
  - Product > 2^FEE_W − 1: fee ← all-ones, fee_sat ← 1. Otherwise fee ← product.
  - Clear the occupied bit, stamp[slot] ← 0, set evt_out, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. evt_in, evt_out, err and fee_sat are valid only while done=1 and are 0 otherwise.
- free_count = N_SLOTS − popcount(occupied), registered, updated the cycle after occupied changes.
- Elapsed time of 0 (same-tick in/out) is legal and gives fee 0. Wrap-around is handled by modular subtraction; stays exceeding 2^TIME_W − 1 ticks alias, which is accepted.
- req_valid while req_ready=0 is ignored; no queuing.

## Timing
- Reset: all outputs 0 except req_ready=1 and free_count=N_SLOTS. Stamps are cleared, FSM goes to IDLE. Asserting rst mid-request aborts the request with no done pulse.
- Accept at edge T (req_valid & req_ready):
  - Check-in: done at T+2.
  - Check-out: done at T+3.
  - Error: done at T+2.
- req_ready returns high the cycle after done. Minimum request spacing is 3 cycles (check-in/error) or 4 cycles (check-out).
- t_req is the timer value sampled at the accept edge; later timer changes do not affect the result.
- fee and elapsed update on the edge entering DONE and hold until the next completed request.

## Structure
- parking_pkg: FSM state enum, slot-ID validity function, saturation helper, default parameter constants.
- One sub-module: parking_fee_calc, containing the combinational grace subtract, multiply and clamp, instantiated in CALC.
- Stamps are held in a register array of N_SLOTS × TIME_W. No RAM is inferred, so all resets are asynchronous.

## Test plan
- Reset, then check-in slot 3 at timer=100 → done at T+2, evt_in=1, occupied=000100, free_count=5, fee=0.
- Check-out slot 3 at timer=250 (RATE=1, GRACE=0) → done at T+3, evt_out=1, elapsed=150, fee=150, occupied=0.
- Wrap: check-in slot 1 at timer=2040, check-out at timer=10 (TIME_W=11) → elapsed=18, fee=18.
- GRACE=20, RATE=3: stay of 15 → fee=0. Stay of 50 → fee=90. RATE=100, FEE_W=8, stay of 10 → fee=255, fee_sat=1.
- req_slot=0 and req_slot=7 (N_SLOTS=6) → err=1, occupied unchanged. Pulse req_valid during CALC → ignored, no second done.
- Check-in slots 1–6 → free_count=0. Assert rst during CALC of a check-out → no done, occupied=0, free_count=6, req_ready=1.
